// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner of the MESI snoop bus: grants one requester, broadcasts its
// miss/invalidate, waits out any dirty write-back, runs the memory fill, then signals done.
module snoop_bus_arbiter #(
    parameter int NPROC  = 3,
    parameter int ADDR_W = 5
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NPROC-1:0]        req,
    input  logic [2*NPROC-1:0]      req_op,
    input  logic [ADDR_W*NPROC-1:0] req_addr,
    output logic [NPROC-1:0]        gnt,
    output logic                    bus_valid,
    output logic [1:0]              bus_op,
    output logic [ADDR_W-1:0]       bus_addr,
    output logic [1:0]              bus_src,
    input  logic [NPROC-1:0]        snoop_abort,
    input  logic                    wb_done,
    output logic                    mem_req,
    input  logic                    mem_ack,
    output logic [NPROC-1:0]        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNOOP,
        S_WB_WAIT,
        S_MEM,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_INV  = 2'd2;
    localparam logic [1:0] RR_INIT = 2'(NPROC - 1);

    state_t              state_q, state_d;
    logic [NPROC-1:0]    gnt_q, gnt_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          src_q, src_d;
    logic [1:0]          rr_q, rr_d;

    logic                win_found;
    logic [1:0]          win_idx;
    logic [1:0]          cand;
    logic [1:0]          win_op;
    logic                abort;

    // Search starts one past the last winner and wraps, so the last owner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= unsigned'(NPROC); k++) begin
            cand = 2'((32'(rr_q) + k) % unsigned'(NPROC));
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_op = req_op[2*int'(win_idx) +: 2];
    assign abort  = |(snoop_abort & ~gnt_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        src_d   = src_q;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    op_d           = (win_op == 2'd3) ? 2'd0 : win_op;
                    addr_d         = req_addr[ADDR_W*int'(win_idx) +: ADDR_W];
                    src_d          = win_idx;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    state_d        = S_SNOOP;
                end
            end
            S_SNOOP: begin
                if (abort)                 state_d = S_WB_WAIT;
                else if (op_q == OP_INV)   state_d = S_DONE;
                else                       state_d = S_MEM;
            end
            S_WB_WAIT: begin
                if (wb_done) state_d = (op_q == OP_INV) ? S_DONE : S_MEM;
            end
            S_MEM: begin
                if (mem_ack) state_d = S_DONE;
            end
            S_DONE: begin
                rr_d    = src_q;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            src_q   <= '0;
            rr_q    <= RR_INIT;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
        end
    end

    assign gnt       = gnt_q;
    assign bus_valid = (state_q == S_SNOOP);
    assign bus_op    = op_q;
    assign bus_addr  = addr_q;
    assign bus_src   = src_q;
    assign mem_req   = (state_q == S_MEM);
    assign done      = (state_q == S_DONE) ? gnt_q : '0;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Scoreboard bench for snoop_bus_arbiter: stimulus queues expected transactions,
// a negedge monitor checks each broadcast and completion against them.
module tb_snoop_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  req;
    logic [5:0]  req_op;
    logic [14:0] req_addr;
    logic [2:0]  gnt;
    logic        bus_valid;
    logic [1:0]  bus_op;
    logic [4:0]  bus_addr;
    logic [1:0]  bus_src;
    logic [2:0]  snoop_abort;
    logic        wb_done;
    logic        mem_req;
    logic        mem_ack;
    logic [2:0]  done;

    snoop_bus_arbiter #(.NPROC(3), .ADDR_W(5)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .bus_valid   (bus_valid),
        .bus_op      (bus_op),
        .bus_addr    (bus_addr),
        .bus_src     (bus_src),
        .snoop_abort (snoop_abort),
        .wb_done     (wb_done),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .done        (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] gnt;
        logic [1:0] op;
        logic [4:0] addr;
        logic [1:0] src;
        int         gc;
        int         mc;
        int         wc;
    } exp_t;

    exp_t q[$];
    exp_t e_m;
    int   total = 0;
    int   bad   = 0;
    int   mem_lat = 1;
    int   mcnt;
    int   gc = 0, mc = 0, wc = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] g, input logic [1:0] op, input logic [4:0] a,
                        input logic [1:0] s, input int gcy, input int mcy, input int wcy);
        exp_t e;
        e.gnt = g; e.op = op; e.addr = a; e.src = s;
        e.gc = gcy; e.mc = mcy; e.wc = wcy;
        q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [4:0] a);
        req_op[2*i +: 2]   = op;
        req_addr[5*i +: 5] = a;
        req[i]             = 1'b1;
    endtask

    task automatic wait_bus(input string name);
        bit seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(posedge clock); #1;
            seen = bus_valid;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s: no bus_valid within 50 cycles", name);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(posedge clock); #1;
            seen = (done != 3'b000);
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s: no done within 50 cycles", name);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    // Memory model: acks in the mem_lat-th cycle of mem_req.
    initial begin
        mem_ack = 1'b0;
        mcnt    = 0;
        forever begin
            @(posedge clock); #1;
            if (mem_req) mcnt++;
            else         mcnt = 0;
            mem_ack = mem_req && (mcnt == mem_lat);
        end
    end

    always @(negedge clock) begin
        if (!reset_n) begin
            q.delete();
            gc = 0; mc = 0; wc = 0;
        end else begin
            if ($countones(gnt) > 1) chk("gnt onehot", $countones(gnt), 1);
            if (gnt == 3'b000 && mem_req) chk("mem_req without gnt", 1, 0);
            if (gnt != 3'b000) begin
                gc++;
                if (mem_req) mc++;
                if (!bus_valid && !mem_req && done == 3'b000) wc++;
            end
            if (bus_valid) begin
                if (q.size() == 0) chk("unexpected bus_valid", 1, 0);
                else begin
                    chk("bus gnt",  gnt,      q[0].gnt);
                    chk("bus_op",   bus_op,   q[0].op);
                    chk("bus_addr", bus_addr, q[0].addr);
                    chk("bus_src",  bus_src,  q[0].src);
                end
            end
            if (done != 3'b000) begin
                if (q.size() == 0) chk("unexpected done", done, 0);
                else begin
                    e_m = q.pop_front();
                    chk("done vec",      done, e_m.gnt);
                    chk("txn gnt cycles", gc,  e_m.gc);
                    chk("txn mem cycles", mc,  e_m.mc);
                    chk("txn wb cycles",  wc,  e_m.wc);
                end
                gc = 0; mc = 0; wc = 0;
            end else if (gnt == 3'b000) begin
                gc = 0; mc = 0; wc = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        req         = '0;
        req_op      = '0;
        req_addr    = '0;
        snoop_abort = '0;
        wb_done     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset gnt",       gnt, 0);
        chk("reset bus_valid", bus_valid, 0);
        chk("reset mem_req",   mem_req, 0);
        chk("reset done",      done, 0);
        chk("reset bus_op",    bus_op, 0);
        chk("reset bus_addr",  bus_addr, 0);
        chk("reset bus_src",   bus_src, 0);
        reset_n = 1'b1;

        // 1: single read miss, two-cycle fill
        mem_lat = 2;
        set_req(0, 2'd0, 5'd5);
        push(3'b001, 2'd0, 5'd5, 2'd0, 4, 2, 0);
        wait_bus("t1 bus");
        wait_done("t1 done");
        @(posedge clock); #1;
        req = '0;
        chk("t1 gnt cleared", gnt, 0);
        mem_lat = 1;

        // 2: all three invalidating, round robin from fresh reset
        do_reset();
        set_req(0, 2'd2, 5'd1);
        set_req(1, 2'd2, 5'd2);
        set_req(2, 2'd2, 5'd3);
        push(3'b001, 2'd2, 5'd1, 2'd0, 2, 0, 0);
        push(3'b010, 2'd2, 5'd2, 2'd1, 2, 0, 0);
        push(3'b100, 2'd2, 5'd3, 2'd2, 2, 0, 0);
        push(3'b001, 2'd2, 5'd1, 2'd0, 2, 0, 0);
        for (int k = 0; k < 4; k++) begin
            wait_done("t2 done");
            if (k == 3) req = '0;
            @(posedge clock); #1;
            chk("t2 idle gap gnt", gnt, 0);
        end

        // 3: write miss hit by another snooper's abort, write-back takes 3 cycles
        set_req(1, 2'd1, 5'd9);
        push(3'b010, 2'd1, 5'd9, 2'd1, 6, 1, 3);
        wait_bus("t3 bus");
        snoop_abort = 3'b100;
        @(posedge clock); #1;
        snoop_abort = '0;
        chk("t3 mem_req wb1", mem_req, 0);
        @(posedge clock); #1;
        chk("t3 mem_req wb2", mem_req, 0);
        @(posedge clock); #1;
        wb_done = 1'b1;
        chk("t3 mem_req wb3", mem_req, 0);
        @(posedge clock); #1;
        wb_done = 1'b0;
        chk("t3 mem_req after wb", mem_req, 1);
        wait_done("t3 done");
        req = '0;

        // 4: invalidate with only own abort bit set
        set_req(0, 2'd2, 5'd7);
        push(3'b001, 2'd2, 5'd7, 2'd0, 2, 0, 0);
        wait_bus("t4 bus");
        snoop_abort = 3'b001;
        @(posedge clock); #1;
        snoop_abort = '0;
        chk("t4 done after snoop", done, 3'b001);
        req = '0;

        // 5: reset during fill, then pointer restarts at proc0
        @(posedge clock); #1;
        mem_lat = 20;
        set_req(1, 2'd0, 5'd4);
        push(3'b010, 2'd0, 5'd4, 2'd1, 0, 0, 0);
        wait_bus("t5 bus");
        @(posedge clock); #1;
        chk("t5 mem_req before reset", mem_req, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5 gnt in reset",     gnt, 0);
        chk("t5 mem_req in reset", mem_req, 0);
        chk("t5 done in reset",    done, 0);
        chk("t5 bus_addr in reset", bus_addr, 0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        mem_lat = 1;
        set_req(0, 2'd0, 5'd12);
        push(3'b001, 2'd0, 5'd12, 2'd0, 3, 1, 0);
        push(3'b010, 2'd0, 5'd4,  2'd1, 3, 1, 0);
        wait_done("t5 done p0");
        req[0] = 1'b0;
        wait_done("t5 done p1");
        req = '0;

        // 6: op 3 normalised to read, stray wb_done in idle, req churn mid-txn
        @(posedge clock); #1;
        wb_done = 1'b1;
        @(posedge clock); #1;
        wb_done = 1'b0;
        chk("t6 idle after wb_done", gnt, 0);
        set_req(2, 2'd3, 5'd31);
        push(3'b100, 2'd0, 5'd31, 2'd2, 3, 1, 0);
        wait_bus("t6 bus");
        req_addr[14:10] = 5'd0;
        req_op[5:4]     = 2'd2;
        wait_done("t6 done");
        chk("t6 bus_addr held", bus_addr, 31);
        chk("t6 bus_op held",   bus_op, 0);
        req = '0;

        repeat (5) @(posedge clock);
        #1;
        chk("queue drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
